maze_run_ctrl: RTL and testbench

Job controller that sequences the maze escaper datapath. It accepts a maze row-by-row over a valid/ready stream and holds the escaper in reset while loading. It then releases the escaper and supervises the run with a cycle budget. Finally it snapshots the visited-cell path and streams it out row-by-row with a status code and cycle count. It sits between the host-side maze source/result sink and one escaper instance.

---
 rtl/maze_pkg.sv | 33 +++
 rtl/maze_result_buffer.sv | 55 +++++
 rtl/maze_run_ctrl.sv | 171 +++++++++++++++++
 tb/tb_maze_run_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : maze_pkg
//  Description : Shared types and constants for the maze run controller and
//                its result buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package maze_pkg;

    // Controller job phases
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Result status codes
    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_TIMEOUT  = 2'd1;
    localparam logic [1:0] ST_NO_ENTRY = 2'd2;

    // Default geometry
    localparam int MAZE_SIZE = 9;
    localparam int MAZE_N    = 4;

    // Width of a row index; never collapses to zero bits
    function automatic int idx_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/maze_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : maze_result_buffer
//  Description : Snapshot of the escaper visited-cell map, serialized out one
//                row per accepted result beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module maze_result_buffer
    import maze_pkg::*;
#(
    parameter int SIZE = MAZE_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   capture,
    input  logic                   clear,
    input  logic [SIZE*SIZE-1:0]   path,
    input  logic                   active,
    input  logic                   advance,
    output logic [SIZE-1:0]        res_row,
    output logic                   res_last
);

    localparam int              c_IW       = idx_width(SIZE);
    localparam logic [c_IW-1:0] c_LAST_ROW = c_IW'(SIZE - 1);

    logic [SIZE*SIZE-1:0] r_snap;
    logic [c_IW-1:0]      r_idx;

    // Snapshot register: clear wins so an aborted job never shows a stale path
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap <= '0;
        end else if (clear) begin
            r_snap <= '0;
        end else if (capture) begin
            r_snap <= path;
        end
    end

    // Output row counter: steps on each accepted beat and wraps after the last row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
        end else if (active && advance) begin
            r_idx <= (r_idx == c_LAST_ROW) ? '0 : r_idx + 1'b1;
        end
    end

    // Row data is only presented while draining; quiet zero otherwise
    assign res_row  = active ? r_snap[r_idx*SIZE +: SIZE] : '0;
    assign res_last = active && (r_idx == c_LAST_ROW);

endmodule
`default_nettype wire

// File: rtl/maze_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : maze_run_ctrl
//  Description : Job controller for the maze escaper: loads a maze row by row,
//                checks entry/exit rows, supervises the escaper run against a
//                cycle budget and streams back the visited path with status.
//  Revision    : 1.0 - initial release
// ============================================================================
module maze_run_ctrl
    import maze_pkg::*;
#(
    parameter int SIZE    = MAZE_SIZE,
    parameter int N       = MAZE_N,
    parameter int TIMEOUT = 1024,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   row_valid,
    output logic                   row_ready,
    input  logic [SIZE-1:0]        row_data,
    output logic                   esc_rst,
    output logic [SIZE*SIZE-1:0]   esc_maze,
    input  logic                   esc_done,
    input  logic [SIZE*SIZE-1:0]   esc_path,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [SIZE-1:0]        res_row,
    output logic                   res_last,
    output logic [1:0]             res_status,
    output logic [CW-1:0]          res_cycles,
    output logic                   busy
);

    localparam int              c_IW        = idx_width(SIZE);
    localparam logic [c_IW-1:0] c_LAST_ROW  = c_IW'(SIZE - 1);
    localparam logic [CW-1:0]   c_CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   c_CNT_LIMIT = CW'(TIMEOUT);

    // The escaper coordinates must be able to address every cell
    generate
        if ((1 << N) < SIZE) begin : g_bad_coord_width
            $error("maze_run_ctrl: N too small for SIZE");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IW-1:0]      r_row_idx;
    logic [SIZE*SIZE-1:0] r_maze;
    logic [CW-1:0]        r_cnt;
    logic [1:0]           r_status;
    logic [CW-1:0]        r_cycles;
    logic                 w_load_hs;
    logic                 w_entry_ok;
    logic                 w_run_end;
    logic                 w_capture;
    logic                 w_clear;

    assign w_load_hs  = (r_state == LOAD) && row_valid;
    // Entry and exit rows each need at least one open cell
    assign w_entry_ok = ~&r_maze[SIZE-1:0] && ~&r_maze[SIZE*SIZE-1 -: SIZE];
    assign w_run_end  = esc_done || (r_cnt == c_CNT_LAST);
    assign w_capture  = (r_state == RUN) && w_run_end;
    assign w_clear    = (r_state == CHECK) && !w_entry_ok;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs (outputs never depend on inputs)
    always_comb begin
        w_state_nxt = r_state;
        row_ready   = 1'b0;
        esc_rst     = 1'b1;
        busy        = 1'b0;
        unique case (r_state)
            LOAD: begin
                row_ready = 1'b1;
                if (row_valid && (r_row_idx == c_LAST_ROW)) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                busy        = 1'b1;
                w_state_nxt = w_entry_ok ? RUN : DRAIN;
            end
            RUN: begin
                busy    = 1'b1;
                esc_rst = 1'b0;
                if (w_run_end) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (res_ready && res_last) begin
                    w_state_nxt = LOAD;
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    // Maze buffer and load row index; buffer only changes while loading
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row_idx <= '0;
            r_maze    <= '1;
        end else if (w_load_hs) begin
            r_maze[r_row_idx*SIZE +: SIZE] <= row_data;
            r_row_idx <= (r_row_idx == c_LAST_ROW) ? '0 : r_row_idx + 1'b1;
        end
    end

    // Run cycle counter: cleared on the check cycle, counts every RUN cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == CHECK) begin
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Result status/cycles: set when the job outcome is decided, held otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_status <= ST_OK;
            r_cycles <= '0;
        end else if (w_clear) begin
            r_status <= ST_NO_ENTRY;
            r_cycles <= '0;
        end else if (w_capture) begin
            if (esc_done) begin
                r_status <= ST_OK;
                r_cycles <= r_cnt;
            end else begin
                r_status <= ST_TIMEOUT;
                r_cycles <= c_CNT_LIMIT;
            end
        end
    end

    maze_result_buffer #(
        .SIZE (SIZE)
    ) u_result_buffer (
        .clk      (clk),
        .rst      (rst),
        .capture  (w_capture),
        .clear    (w_clear),
        .path     (esc_path),
        .active   (res_valid),
        .advance  (res_ready),
        .res_row  (res_row),
        .res_last (res_last)
    );

    assign esc_maze   = r_maze;
    assign res_valid  = (r_state == DRAIN);
    assign res_status = r_status;
    assign res_cycles = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_maze_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maze_run_ctrl
//  Description : Directed scoreboard bench for maze_run_ctrl; the bench plays
//                both host and escaper.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_run_ctrl;

    localparam int SIZE    = 9;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(TIMEOUT + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 row_valid;
    logic                 row_ready;
    logic [SIZE-1:0]      row_data;
    logic                 esc_rst;
    logic [SIZE*SIZE-1:0] esc_maze;
    logic                 esc_done;
    logic [SIZE*SIZE-1:0] esc_path;
    logic                 res_valid;
    logic                 res_ready;
    logic [SIZE-1:0]      res_row;
    logic                 res_last;
    logic [1:0]           res_status;
    logic [CW-1:0]        res_cycles;
    logic                 busy;

    maze_run_ctrl #(
        .SIZE    (SIZE),
        .N       (4),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_data   (row_data),
        .esc_rst    (esc_rst),
        .esc_maze   (esc_maze),
        .esc_done   (esc_done),
        .esc_path   (esc_path),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_row    (res_row),
        .res_last   (res_last),
        .res_status (res_status),
        .res_cycles (res_cycles),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SIZE-1:0] row;
        logic            last;
        logic [1:0]      status;
        logic [CW-1:0]   cycles;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted result beat is checked against the scoreboard
    always @(negedge clk) begin
        if (rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_beat: got row %0h with empty scoreboard", res_row);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_row",    res_row,    e.row);
                chk("res_last",   res_last,   e.last);
                chk("res_status", res_status, e.status);
                chk("res_cycles", res_cycles, e.cycles);
            end
        end
    end

    function automatic logic [SIZE*SIZE-1:0] fill(input logic [SIZE-1:0] v);
        logic [SIZE*SIZE-1:0] m;
        for (int r = 0; r < SIZE; r++) m[r*SIZE +: SIZE] = v;
        return m;
    endfunction

    // Host side: offer all rows, optionally with two idle cycles between rows
    task automatic load_maze(input logic [SIZE*SIZE-1:0] maze, input bit gaps);
        for (int r = 0; r < SIZE; r++) begin
            chk("row_ready", row_ready, 1'b1);
            row_valid = 1'b1;
            row_data  = maze[r*SIZE +: SIZE];
            @(posedge clk); #1;
            row_valid = 1'b0;
            row_data  = 9'h155;
            if (gaps && r < SIZE - 1) begin
                repeat (2) begin @(posedge clk); #1; end
            end
        end
        chk("check_busy",    busy,     1'b1);
        chk("check_esc_rst", esc_rst,  1'b1);
        chk("esc_maze",      esc_maze, maze);
    endtask

    // Escaper side: kind 0 = reaches exit after delay, 1 = never finishes, 2 = blocked
    task automatic run_escaper(input int kind, input int delay, input logic [SIZE*SIZE-1:0] path);
        int n;
        @(posedge clk); #1;
        if (kind == 2) begin
            chk("blocked_esc_rst", esc_rst,   1'b1);
            chk("blocked_valid",   res_valid, 1'b1);
        end else begin
            chk("run_esc_rst", esc_rst, 1'b0);
            esc_path = path;
            if (kind == 0) begin
                repeat (delay) begin @(posedge clk); #1; end
                esc_done = 1'b1;
                @(posedge clk); #1;
                esc_done = 1'b0;
                chk("done_to_valid", res_valid, 1'b1);
            end else begin
                n = 0;
                while (!res_valid && n < 40) begin
                    @(posedge clk); #1;
                    n++;
                end
                chk("timeout_latency", n, TIMEOUT);
            end
        end
    endtask

    // Sink side: accept all rows, optionally stalling while a given row is shown
    task automatic drain(input int stall_row, input int stall_len, input logic [SIZE-1:0] hold_val);
        int hs, stall, guard;
        hs = 0; stall = 0; guard = 0;
        while (hs < SIZE && guard < 200) begin
            if (hs == stall_row && stall < stall_len) begin
                res_ready = 1'b0;
                stall++;
            end else begin
                res_ready = 1'b1;
            end
            @(negedge clk);
            if (!res_ready) begin
                chk("bp_valid", res_valid, 1'b1);
                chk("bp_hold",  res_row,   hold_val);
            end
            if (res_valid && res_ready) hs++;
            @(posedge clk); #1;
            guard++;
        end
        res_ready = 1'b0;
        chk("drain_rows",  hs,        SIZE);
        chk("idle_busy",   busy,      1'b0);
        chk("idle_valid",  res_valid, 1'b0);
        chk("idle_ready",  row_ready, 1'b1);
    endtask

    task automatic do_job(input logic [SIZE*SIZE-1:0] maze, input bit gaps, input int kind,
                          input int delay, input logic [SIZE*SIZE-1:0] path,
                          input int stall_row, input int stall_len);
        exp_t                 e;
        logic [SIZE*SIZE-1:0] p;
        p = (kind == 2) ? '0 : path;
        for (int r = 0; r < SIZE; r++) begin
            e.row    = p[r*SIZE +: SIZE];
            e.last   = (r == SIZE - 1);
            e.status = (kind == 0) ? 2'd0 : (kind == 1) ? 2'd1 : 2'd2;
            e.cycles = (kind == 0) ? CW'(delay) : (kind == 1) ? CW'(TIMEOUT) : '0;
            exp_q.push_back(e);
        end
        load_maze(maze, gaps);
        run_escaper(kind, delay, path);
        drain(stall_row, stall_len, (stall_len > 0) ? p[stall_row*SIZE +: SIZE] : '0);
    endtask

    logic [SIZE*SIZE-1:0] corridor, corr_path, m, pth;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; row_valid = 1'b0; row_data = '0;
        esc_done = 1'b0; esc_path = '0; res_ready = 1'b0;
        corridor  = fill(9'h1FD);
        corr_path = fill(9'h002);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_row_ready",  row_ready,  1'b1);
        chk("rst_esc_rst",    esc_rst,    1'b1);
        chk("rst_esc_maze",   esc_maze,   {(SIZE*SIZE){1'b1}});
        chk("rst_res_valid",  res_valid,  1'b0);
        chk("rst_res_row",    res_row,    9'h000);
        chk("rst_res_last",   res_last,   1'b0);
        chk("rst_res_status", res_status, 2'd0);
        chk("rst_res_cycles", res_cycles, 5'd0);
        chk("rst_busy",       busy,       1'b0);
        @(posedge clk); #1;

        // Straight corridor
        do_job(corridor, 1'b0, 0, 5, corr_path, 0, 0);

        // Blocked entry row
        m = corridor;
        m[8:0] = 9'h1FF;
        do_job(m, 1'b0, 2, 0, corr_path, 0, 0);

        // Exit open but unreachable: wall row in the middle
        m = corridor;
        m[4*SIZE +: SIZE] = 9'h1FF;
        pth = '0;
        for (int r = 0; r < 4; r++) pth[r*SIZE +: SIZE] = 9'h002;
        do_job(m, 1'b0, 1, 0, pth, 0, 0);

        // Backpressure with distinct rows so order is visible
        for (int r = 0; r < SIZE; r++) pth[r*SIZE +: SIZE] = 9'(1 << r);
        do_job(corridor, 1'b0, 0, 3, pth, 3, 5);

        // Load gaps with distinct row contents
        m = corridor;
        m[1*SIZE +: SIZE] = 9'h101;
        m[2*SIZE +: SIZE] = 9'h0F0;
        m[3*SIZE +: SIZE] = 9'h0AA;
        m[5*SIZE +: SIZE] = 9'h13C;
        m[7*SIZE +: SIZE] = 9'h001;
        m[8*SIZE +: SIZE] = 9'h0FF;
        do_job(m, 1'b1, 0, 2, corr_path, 0, 0);

        // Reset during RUN, then a normal job
        load_maze(corridor, 1'b0);
        @(posedge clk); #1;
        chk("pre_abort_esc_rst", esc_rst, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        chk("abort_esc_rst",  esc_rst,   1'b1);
        chk("abort_valid",    res_valid, 1'b0);
        chk("abort_busy",     busy,      1'b0);
        chk("abort_esc_maze", esc_maze,  {(SIZE*SIZE){1'b1}});
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_row_ready", row_ready, 1'b1);
        @(posedge clk); #1;
        do_job(corridor, 1'b0, 0, 4, corr_path, 0, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
